// File: rtl/arm_regfile_pkg.sv
// Package for the ARMv4-style banked register file.
// Holds the mode encodings, the physical entry indices of the banked
// registers and small helpers for checking a mode and selecting its SPSR.
package arm_regfile_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int NUM_PHY  = 31;
  localparam int NUM_SPSR = 5;

  localparam logic [4:0] PHY_FIQ_R8  = 5'd16;
  localparam logic [4:0] PHY_FIQ_R13 = 5'd21;
  localparam logic [4:0] PHY_FIQ_R14 = 5'd22;
  localparam logic [4:0] PHY_IRQ_R13 = 5'd23;
  localparam logic [4:0] PHY_IRQ_R14 = 5'd24;
  localparam logic [4:0] PHY_SVC_R13 = 5'd25;
  localparam logic [4:0] PHY_SVC_R14 = 5'd26;
  localparam logic [4:0] PHY_ABT_R13 = 5'd27;
  localparam logic [4:0] PHY_ABT_R14 = 5'd28;
  localparam logic [4:0] PHY_UND_R13 = 5'd29;
  localparam logic [4:0] PHY_UND_R14 = 5'd30;

  // SPSR slot per exception mode; usr/sys have none.
  localparam logic [2:0] SPSR_FIQ  = 3'd0;
  localparam logic [2:0] SPSR_IRQ  = 3'd1;
  localparam logic [2:0] SPSR_SVC  = 3'd2;
  localparam logic [2:0] SPSR_ABT  = 3'd3;
  localparam logic [2:0] SPSR_UND  = 3'd4;
  localparam logic [2:0] SPSR_NONE = 3'd7;

  function automatic logic is_legal_mode(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] spsr_sel(input logic [4:0] m);
    case (m)
      MODE_FIQ: return SPSR_FIQ;
      MODE_IRQ: return SPSR_IRQ;
      MODE_SVC: return SPSR_SVC;
      MODE_ABT: return SPSR_ABT;
      MODE_UND: return SPSR_UND;
      default:  return SPSR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arm_bank_map.sv
// Logical-to-physical register mapper (combinational).
// Ports:
//   addr_i  logical register R0..R15
//   mode_i  current processor mode (M[4:0])
//   usr_i   force the usr/sys column regardless of mode
//   phy_o   physical entry index 0..30
module arm_bank_map
  import arm_regfile_pkg::*;
(
  input  logic [3:0] addr_i,
  input  logic [4:0] mode_i,
  input  logic       usr_i,
  output logic [4:0] phy_o
);

  logic [4:0] r13_base;
  logic       r13_banked;

  // Base index of the R13/R14 pair for the non-fiq exception modes.
  always_comb begin
    r13_base   = 5'd13;
    r13_banked = 1'b1;
    case (mode_i)
      MODE_IRQ: r13_base = PHY_IRQ_R13;
      MODE_SVC: r13_base = PHY_SVC_R13;
      MODE_ABT: r13_base = PHY_ABT_R13;
      MODE_UND: r13_base = PHY_UND_R13;
      default:  r13_banked = 1'b0;
    endcase
  end

  always_comb begin
    phy_o = {1'b0, addr_i};
    // R0-R7 and R15 are shared by every mode.
    if (!usr_i && addr_i[3] && (addr_i != 4'd15)) begin
      if (mode_i == MODE_FIQ) begin
        phy_o = PHY_FIQ_R8 + {2'b00, addr_i[2:0]};
      end else if (r13_banked && (addr_i == 4'd13)) begin
        phy_o = r13_base;
      end else if (r13_banked && (addr_i == 4'd14)) begin
        phy_o = r13_base + 5'd1;
      end
    end
  end

endmodule

// File: rtl/arm_banked_regfile.sv
// ARMv4-style banked register file: 16 logical registers over 31 physical
// entries, mode register, NUM_RD registered read ports and one write port.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   mode_we/mode_wdata      mode change request; mode_q current mode
//   mode_err                one-cycle pulse after an illegal mode request
//   rd_en/rd_addr/rd_usr    per-port read request, packed per port
//   rd_data/rd_valid        per-port read result, one cycle latency
//   wr_en/wr_addr/wr_usr/wr_data  write port
// Optional build macro ARM_REGFILE_SPSR_EN adds spsr_we, spsr_wdata and
// spsr_rdata with one SPSR per exception mode.
module arm_banked_regfile #(
  parameter int         DATA_W     = 32,
  parameter int         NUM_RD     = 2,
  parameter logic [4:0] RESET_MODE = 5'b10011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_we,
  input  logic [4:0]               mode_wdata,
  output logic [4:0]               mode_q,
  output logic                     mode_err,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  input  logic [NUM_RD-1:0]        rd_usr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic                     wr_usr,
  input  logic [DATA_W-1:0]        wr_data
`ifdef ARM_REGFILE_SPSR_EN
  ,
  input  logic                     spsr_we,
  input  logic [31:0]              spsr_wdata,
  output logic [31:0]              spsr_rdata
`endif
);
  import arm_regfile_pkg::*;

  logic [DATA_W-1:0] regs_q [NUM_PHY];
  logic [4:0]        mode_d, mode_r_q;
  logic              mode_err_d, mode_err_q;
  logic [4:0]        wr_phy;
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q;

  assign mode_q   = mode_r_q;
  assign mode_err = mode_err_q;
  assign rd_valid = rd_valid_q;

  // An illegal request keeps the old mode and is flagged next cycle.
  always_comb begin
    mode_d     = mode_r_q;
    mode_err_d = 1'b0;
    if (mode_we) begin
      if (is_legal_mode(mode_wdata)) mode_d = mode_wdata;
      else                           mode_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r_q   <= RESET_MODE;
      mode_err_q <= 1'b0;
    end else begin
      mode_r_q   <= mode_d;
      mode_err_q <= mode_err_d;
    end
  end

  arm_bank_map u_wr_map (
    .addr_i (wr_addr),
    .mode_i (mode_r_q),
    .usr_i  (wr_usr),
    .phy_o  (wr_phy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHY; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_phy] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [4:0] rd_phy;

    arm_bank_map u_rd_map (
      .addr_i (rd_addr[p*4 +: 4]),
      .mode_i (mode_r_q),
      .usr_i  (rd_usr[p]),
      .phy_o  (rd_phy)
    );

    // Write-first bypass only when both resolve to the same physical entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q[p]  <= '0;
        rd_valid_q[p] <= 1'b0;
      end else begin
        rd_valid_q[p] <= rd_en[p];
        if (rd_en[p]) begin
          rd_data_q[p] <= (wr_en && (wr_phy == rd_phy)) ? wr_data : regs_q[rd_phy];
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rd_data_q[p];
  end

`ifdef ARM_REGFILE_SPSR_EN
  logic [31:0] spsr_q [NUM_SPSR];
  logic [2:0]  spsr_idx;

  assign spsr_idx   = spsr_sel(mode_r_q);
  assign spsr_rdata = (spsr_idx == SPSR_NONE) ? 32'h0 : spsr_q[spsr_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
    end else if (spsr_we && (spsr_idx != SPSR_NONE)) begin
      spsr_q[spsr_idx] <= spsr_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_arm_banked_regfile.sv
module tb_arm_banked_regfile;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_we;
  logic [4:0]  mode_wdata;
  logic [4:0]  mode_q;
  logic        mode_err;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_usr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        wr_usr;
  logic [31:0] wr_data;
`ifdef ARM_REGFILE_SPSR_EN
  logic        spsr_we;
  logic [31:0] spsr_wdata;
  logic [31:0] spsr_rdata;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arm_banked_regfile #(.DATA_W(32), .NUM_RD(2), .RESET_MODE(5'b10011)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_we    (mode_we),
    .mode_wdata (mode_wdata),
    .mode_q     (mode_q),
    .mode_err   (mode_err),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_usr     (rd_usr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_usr     (wr_usr),
    .wr_data    (wr_data)
`ifdef ARM_REGFILE_SPSR_EN
    ,
    .spsr_we    (spsr_we),
    .spsr_wdata (spsr_wdata),
    .spsr_rdata (spsr_rdata)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [4:0] m);
    mode_we    = 1'b1;
    mode_wdata = m;
    tick();
    mode_we    = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic u);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_usr  = u;
    tick();
    wr_en   = 1'b0;
    wr_usr  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1,
                    input logic [1:0] en, input logic [1:0] u);
    rd_en   = en;
    rd_addr = {a1, a0};
    rd_usr  = u;
    tick();
    rd_en   = 2'b00;
    rd_usr  = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; mode_we = 1'b0; mode_wdata = '0;
    rd_en = '0; rd_addr = '0; rd_usr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_usr = 1'b0; wr_data = '0;
`ifdef ARM_REGFILE_SPSR_EN
    spsr_we = 1'b0; spsr_wdata = '0;
`endif
    #12;
    chk("rst_mode", {27'd0, mode_q}, {27'd0, M_SVC});
    chk("rst_valid", {30'd0, rd_valid}, 32'd0);
    chk("rst_err", {31'd0, mode_err}, 32'd0);
    chk("rst_data", rd_data[31:0], 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Every register reads zero after reset in svc.
    for (int r = 0; r < 16; r++) begin
      rd(r[3:0], 4'd0, 2'b01, 2'b00);
      chk($sformatf("svc_r%0d", r), rd_data[31:0], 32'd0);
      chk($sformatf("svc_v%0d", r), {31'd0, rd_valid[0]}, 32'd1);
    end
    tick();
    chk("valid_drop", {30'd0, rd_valid}, 32'd0);

    // usr vs irq R13.
    set_mode(M_USR);
    chk("mode_usr", {27'd0, mode_q}, {27'd0, M_USR});
    wr(4'd13, 32'h1111, 1'b0);
    set_mode(M_IRQ);
    wr(4'd13, 32'h2222, 1'b0);
    rd(4'd13, 4'd0, 2'b01, 2'b00);
    chk("irq_r13", rd_data[31:0], 32'h2222);
    rd(4'd13, 4'd0, 2'b01, 2'b01);
    chk("irq_r13_usr", rd_data[31:0], 32'h1111);

    // fiq R8 banked, R7 shared.
    set_mode(M_FIQ);
    wr(4'd8, 32'hAAAA, 1'b0);
    wr(4'd7, 32'h7777, 1'b0);
    set_mode(M_USR);
    rd(4'd8, 4'd7, 2'b11, 2'b00);
    chk("usr_r8", rd_data[31:0], 32'h0);
    chk("usr_r7", rd_data[63:32], 32'h7777);
    set_mode(M_FIQ);
    rd(4'd8, 4'd7, 2'b11, 2'b00);
    chk("fiq_r8", rd_data[31:0], 32'hAAAA);
    chk("fiq_r7", rd_data[63:32], 32'h7777);
    rd(4'd13, 4'd14, 2'b11, 2'b00);
    chk("fiq_r13", rd_data[31:0], 32'h0);
    chk("fiq_r14", rd_data[63:32], 32'h0);

    // fiq R8 write vs usr R8 read: different entries, no bypass.
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'hBBBB;
    rd(4'd8, 4'd8, 2'b11, 2'b01);
    wr_en = 1'b0;
    chk("fiq_nobyp_usr", rd_data[31:0], 32'h0);
    chk("fiq_byp", rd_data[63:32], 32'hBBBB);

    // Write-first collision in svc.
    set_mode(M_SVC);
    wr(4'd14, 32'h5555, 1'b1);
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'hDEAD;
    rd(4'd14, 4'd14, 2'b11, 2'b00);
    wr_en = 1'b0;
    chk("byp_p0", rd_data[31:0], 32'hDEAD);
    chk("byp_p1", rd_data[63:32], 32'hDEAD);
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'hBEEF;
    rd(4'd14, 4'd14, 2'b11, 2'b01);
    wr_en = 1'b0;
    chk("nobyp_usr", rd_data[31:0], 32'h5555);
    chk("byp_svc", rd_data[63:32], 32'hBEEF);
    rd(4'd14, 4'd15, 2'b11, 2'b00);
    chk("svc_r14", rd_data[31:0], 32'hBEEF);
    chk("svc_r15", rd_data[63:32], 32'h0);

    // Illegal mode request in abt.
    set_mode(M_ABT);
    set_mode(5'b00101);
    chk("ill_mode", {27'd0, mode_q}, {27'd0, M_ABT});
    chk("ill_err", {31'd0, mode_err}, 32'd1);
    tick();
    chk("ill_err_drop", {31'd0, mode_err}, 32'd0);

    // Write in the same cycle as a mode change lands in the old bank.
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hABAB;
    set_mode(M_UND);
    wr_en = 1'b0;
    chk("mode_und", {27'd0, mode_q}, {27'd0, M_UND});
    chk("und_err", {31'd0, mode_err}, 32'd0);
    rd(4'd13, 4'd0, 2'b01, 2'b00);
    chk("und_r13", rd_data[31:0], 32'h0);
    set_mode(M_ABT);
    rd(4'd13, 4'd0, 2'b01, 2'b00);
    chk("abt_r13", rd_data[31:0], 32'hABAB);
    set_mode(M_SYS);
    rd(4'd13, 4'd14, 2'b11, 2'b00);
    chk("sys_r13", rd_data[31:0], 32'h1111);
    chk("sys_r14", rd_data[63:32], 32'h5555);

`ifdef ARM_REGFILE_SPSR_EN
    set_mode(M_SVC);
    spsr_we = 1'b1; spsr_wdata = 32'h600000D3;
    tick();
    spsr_we = 1'b0;
    chk("spsr_svc", spsr_rdata, 32'h600000D3);
    set_mode(M_USR);
    chk("spsr_usr", spsr_rdata, 32'h0);
    spsr_we = 1'b1; spsr_wdata = 32'h12345678;
    tick();
    spsr_we = 1'b0;
    chk("spsr_usr_we", spsr_rdata, 32'h0);
    set_mode(M_SVC);
    chk("spsr_svc_keep", spsr_rdata, 32'h600000D3);
`endif

    // Async reset mid-operation, with a write pending across the edge.
    rd_en = 2'b01; rd_addr = 8'h0D; rd_usr = 2'b00;
    tick();
    chk("pre_rst_valid", {31'd0, rd_valid[0]}, 32'd1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF;
    mode_we = 1'b1; mode_wdata = M_FIQ;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mode", {27'd0, mode_q}, {27'd0, M_SVC});
    chk("arst_valid", {30'd0, rd_valid}, 32'd0);
    chk("arst_data", rd_data[31:0], 32'd0);
    tick();
    rd_en = 2'b00; wr_en = 1'b0; mode_we = 1'b0;
    #2 rst_n = 1'b1;
`ifdef ARM_REGFILE_SPSR_EN
    chk("arst_spsr", spsr_rdata, 32'h0);
`endif
    tick();
    rd(4'd0, 4'd13, 2'b11, 2'b11);
    chk("arst_r0", rd_data[31:0], 32'h0);
    chk("arst_r13", rd_data[63:32], 32'h0);
    set_mode(M_IRQ);
    rd(4'd13, 4'd0, 2'b01, 2'b00);
    chk("arst_irq_r13", rd_data[31:0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
